tdm_demux8: RTL

Receive-side counterpart of the 8-to-1 mux datapath: an 8-slot time-division demultiplexer/deserializer. A transmitter sweeps its mux select 0..7 and emits one bit per slot on a single serial line; this block tracks the slot number with a 3-bit counter. It steers each bit into slot position `o[s]` through a 3-to-8 one-hot decode and presents the completed 8-bit frame on a registered valid/ready output port.

---
 rtl/tdm_demux8.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: 8-slot time-division demultiplexer / deserializer.
// Tracks the transmitter's slot number with a 3-bit counter and steers each
// strobed serial bit into a staging register through a one-hot slot decode.
// Completed frames are presented on a registered valid/ready output port.
// A frame that completes while the output still holds an unconsumed frame
// is dropped and flagged with a one-cycle ovf pulse.
module tdm_demux8 #(
   parameter bit FRAME_RESYNC = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       frame,
   input  logic       din,
   input  logic       ready,
   output logic [2:0] s,
   output logic [0:7] o,
   output logic       valid,
   output logic       ovf
);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] s_nxt;
   logic       wr_en;
   logic [2:0] wr_slot;
   logic       complete;
   logic [0:7] slot_sel;
   logic [0:7] stg;
   logic       load_ok;
   logic       load;
   logic       drop;

   // State and slot counter register; reset abandons any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 3'd0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
      end
   end

   // Next-state logic: decides which slot the strobed bit lands in and
   // whether this strobe completes the frame.
   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      wr_en     = 1'b0;
      wr_slot   = s;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (en && frame) begin
               wr_en     = 1'b1;
               wr_slot   = 3'd0;
               s_nxt     = 3'd1;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (en) begin
               if (frame && FRAME_RESYNC) begin
                  wr_en   = 1'b1;
                  wr_slot = 3'd0;
                  s_nxt   = 3'd1;
               end else begin
                  wr_en   = 1'b1;
                  wr_slot = s;
                  s_nxt   = s + 3'd1;
                  if (s == 3'd7) begin
                     complete  = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            s_nxt     = 3'd0;
         end
      endcase
   end

   // One-hot decode of the target slot, so each staging bit has its own enable.
   always_comb begin
      slot_sel = 8'h00;
      if (wr_en) begin
         slot_sel[wr_slot] = 1'b1;
      end
   end

   // Staging register: each bit captures din only when its slot is selected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= 8'h00;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (slot_sel[k]) begin
               stg[k] <= din;
            end
         end
      end
   end

   // A completed frame may load when the output is empty or being consumed now.
   always_comb begin
      load_ok = !valid || ready;
      load    = complete && load_ok;
      drop    = complete && !load_ok;
   end

   // Output port: load bypasses the slot-7 bit straight from din so the frame
   // is visible the cycle after its last strobe; otherwise a handshake empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o     <= 8'h00;
         valid <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (load) begin
            o     <= {stg[0:6], din};
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         ovf <= drop;
      end
   end

endmodule
